// File: rtl/pipelined_control_unit.sv
// Pipelined control unit for the 5-stage RV32I core.
// Decodes the instruction in ID, carries its control word through ID/EX,
// a MEM_STAGES-deep memory chain and a final write-back register.
// MEM_STAGES is meaningful for 1..3; ALU_CTRL_W must be at least 4.
module pipelined_control_unit #(
  parameter int MEM_STAGES = 1,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [6:0]            Opcode_D,
  input  logic [2:0]            Funct3_D,
  input  logic                  Funct7_5_D,
  input  logic                  Stall_E,
  input  logic                  Flush_E,
  input  logic                  Zero_E,
  input  logic                  Lt_E,
  input  logic                  Ltu_E,
  output logic [2:0]            ImmSrc_D,
  output logic                  Illegal_D,
  output logic                  AluSrcA_E,
  output logic [1:0]            AluSrcB_E,
  output logic [ALU_CTRL_W-1:0] AluControl_E,
  output logic                  LoadInE_E,
  output logic                  PCSrc_E,
  output logic                  PCJalr_E,
  output logic                  MemWrite_M,
  output logic                  RegWrite_M,
  output logic [2:0]            Funct3_M,
  output logic                  RegWrite_W,
  output logic [1:0]            ResultSrc_W
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Full control word held in ID/EX.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [2:0] funct3;
  } ex_ctrl_t;

  // Subset that survives past EX into the memory stages.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [2:0] funct3;
  } mem_ctrl_t;

  // Subset needed by write-back.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } wb_ctrl_t;

  // ALU operation for R-type and I-ALU; alt selects sub/sra.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  ex_ctrl_t  dec;
  logic [2:0] imm_src;
  logic       illegal;
  ex_ctrl_t  ex_q;
  mem_ctrl_t m_in;
  mem_ctrl_t m_q [MEM_STAGES];
  wb_ctrl_t  w_q;
  logic      branch_cond;

  // Main decode in ID; unknown opcodes decode to an all-zero control word.
  always_comb begin
    dec        = '0;
    imm_src    = IMM_I;
    illegal    = 1'b0;
    dec.funct3 = Funct3_D;
    case (Opcode_D)
      OP_LOAD: begin
        dec.reg_write   = 1'b1;
        imm_src         = IMM_I;
        dec.alu_src_b   = SRCB_IMM;
        dec.result_src  = RES_MEM;
        dec.alu_control = ALU_ADD;
      end
      OP_STORE: begin
        dec.mem_write   = 1'b1;
        imm_src         = IMM_S;
        dec.alu_src_b   = SRCB_IMM;
        dec.alu_control = ALU_ADD;
      end
      OP_R: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_b   = SRCB_RS2;
        dec.alu_control = alu_decode(Funct3_D, Funct7_5_D);
      end
      OP_I: begin
        // Only SRAI uses instruction[30]; for ADDI etc. it is immediate data.
        dec.reg_write   = 1'b1;
        imm_src         = IMM_I;
        dec.alu_src_b   = SRCB_IMM;
        dec.alu_control = alu_decode(Funct3_D, (Funct3_D == 3'b101) & Funct7_5_D);
      end
      OP_BRANCH: begin
        dec.branch      = 1'b1;
        imm_src         = IMM_B;
        dec.alu_src_b   = SRCB_RS2;
        dec.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        dec.jump        = 1'b1;
        dec.reg_write   = 1'b1;
        imm_src         = IMM_J;
        dec.result_src  = RES_PC4;
      end
      OP_JALR: begin
        dec.jump        = 1'b1;
        dec.jalr        = 1'b1;
        dec.reg_write   = 1'b1;
        imm_src         = IMM_I;
        dec.alu_src_b   = SRCB_IMM;
        dec.alu_control = ALU_ADD;
        dec.result_src  = RES_PC4;
      end
      OP_LUI: begin
        dec.reg_write   = 1'b1;
        imm_src         = IMM_U;
        dec.alu_src_b   = SRCB_IMM;
        dec.alu_control = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec.reg_write   = 1'b1;
        imm_src         = IMM_U;
        dec.alu_src_a   = 1'b1;
        dec.alu_src_b   = SRCB_IMM;
        dec.alu_control = ALU_ADD;
      end
      default: begin
        dec     = '0;
        imm_src = IMM_I;
        illegal = 1'b1;
      end
    endcase
  end

  assign ImmSrc_D  = imm_src;
  assign Illegal_D = illegal;

  // ID/EX register: flush beats stall, stall holds, otherwise load decode.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ex_q <= '0;
    end else if (Flush_E) begin
      ex_q <= '0;
    end else if (!Stall_E) begin
      ex_q <= dec;
    end
  end

  // Branch condition selected by the EX funct3; 010/011 never take.
  always_comb begin
    branch_cond = 1'b0;
    case (ex_q.funct3)
      3'b000:  branch_cond = Zero_E;
      3'b001:  branch_cond = ~Zero_E;
      3'b100:  branch_cond = Lt_E;
      3'b101:  branch_cond = ~Lt_E;
      3'b110:  branch_cond = Ltu_E;
      3'b111:  branch_cond = ~Ltu_E;
      default: branch_cond = 1'b0;
    endcase
  end

  assign AluSrcA_E    = ex_q.alu_src_a;
  assign AluSrcB_E    = ex_q.alu_src_b;
  assign AluControl_E = ALU_CTRL_W'(ex_q.alu_control);
  assign LoadInE_E    = (ex_q.result_src == RES_MEM);
  assign PCSrc_E      = (ex_q.branch & branch_cond) | ex_q.jump;
  assign PCJalr_E     = ex_q.jalr;

  // Entry into the memory chain: a bubble while EX is held by a stall.
  // With flush and stall together the EX instruction still moves on,
  // because the flush only clears what ID/EX loads next.
  always_comb begin
    m_in = '{reg_write:  ex_q.reg_write,
             mem_write:  ex_q.mem_write,
             result_src: ex_q.result_src,
             funct3:     ex_q.funct3};
    if (Stall_E && !Flush_E) begin
      m_in = '0;
    end
  end

  // Memory-stage shift chain, MEM_STAGES registers deep.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < MEM_STAGES; i++) begin
        m_q[i] <= '0;
      end
    end else begin
      m_q[0] <= m_in;
      for (int i = 1; i < MEM_STAGES; i++) begin
        m_q[i] <= m_q[i-1];
      end
    end
  end

  // Write-back register fed from the last memory stage.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      w_q <= '0;
    end else begin
      w_q <= '{reg_write:  m_q[MEM_STAGES-1].reg_write,
               result_src: m_q[MEM_STAGES-1].result_src};
    end
  end

  assign MemWrite_M  = m_q[0].mem_write;
  assign RegWrite_M  = m_q[0].reg_write;
  assign Funct3_M    = m_q[0].funct3;
  assign RegWrite_W  = w_q.reg_write;
  assign ResultSrc_W = w_q.result_src;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: two instances (MEM_STAGES=1 and 3)
// share one stimulus stream. Directed vectors push expected values,
// stamped with the clock edge at which they must appear, into exp_q; a
// negedge monitor compares every entry due at the current edge.
module tb_pipelined_control_unit;

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int SIG_IMM = 0, SIG_ILL = 1, SIG_SRCA = 2, SIG_SRCB = 3;
  localparam int SIG_ALU = 4, SIG_LOADE = 5, SIG_PCSRC = 6, SIG_JALR = 7;
  localparam int SIG_MEMW_M = 8, SIG_REGW_M = 9, SIG_F3_M = 10;
  localparam int SIG_REGW_W = 11, SIG_RES_W = 12;

  // ---------------- clock / reset / DUT ----------------
  logic       Clk = 1'b0;
  logic       Reset;
  logic [6:0] Opcode_D;
  logic [2:0] Funct3_D;
  logic       Funct7_5_D, Stall_E, Flush_E, Zero_E, Lt_E, Ltu_E;

  logic [2:0] imm_src [2];
  logic       illegal [2];
  logic       src_a [2];
  logic [1:0] src_b [2];
  logic [3:0] alu_ctrl [2];
  logic       load_e [2];
  logic       pc_src [2];
  logic       pc_jalr [2];
  logic       mem_write_m [2];
  logic       reg_write_m [2];
  logic [2:0] funct3_m [2];
  logic       reg_write_w [2];
  logic [1:0] result_src_w [2];

  int edges = 0;
  int n_compared = 0;
  int n_mismatched = 0;
  logic [31:0] exp_q[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) edges <= edges + 1;

  pipelined_control_unit #(.MEM_STAGES(1), .ALU_CTRL_W(4)) u_dut_ms1 (
    .Clk(Clk), .Reset(Reset), .Opcode_D(Opcode_D), .Funct3_D(Funct3_D),
    .Funct7_5_D(Funct7_5_D), .Stall_E(Stall_E), .Flush_E(Flush_E),
    .Zero_E(Zero_E), .Lt_E(Lt_E), .Ltu_E(Ltu_E),
    .ImmSrc_D(imm_src[0]), .Illegal_D(illegal[0]), .AluSrcA_E(src_a[0]),
    .AluSrcB_E(src_b[0]), .AluControl_E(alu_ctrl[0]), .LoadInE_E(load_e[0]),
    .PCSrc_E(pc_src[0]), .PCJalr_E(pc_jalr[0]), .MemWrite_M(mem_write_m[0]),
    .RegWrite_M(reg_write_m[0]), .Funct3_M(funct3_m[0]),
    .RegWrite_W(reg_write_w[0]), .ResultSrc_W(result_src_w[0])
  );

  pipelined_control_unit #(.MEM_STAGES(3), .ALU_CTRL_W(4)) u_dut_ms3 (
    .Clk(Clk), .Reset(Reset), .Opcode_D(Opcode_D), .Funct3_D(Funct3_D),
    .Funct7_5_D(Funct7_5_D), .Stall_E(Stall_E), .Flush_E(Flush_E),
    .Zero_E(Zero_E), .Lt_E(Lt_E), .Ltu_E(Ltu_E),
    .ImmSrc_D(imm_src[1]), .Illegal_D(illegal[1]), .AluSrcA_E(src_a[1]),
    .AluSrcB_E(src_b[1]), .AluControl_E(alu_ctrl[1]), .LoadInE_E(load_e[1]),
    .PCSrc_E(pc_src[1]), .PCJalr_E(pc_jalr[1]), .MemWrite_M(mem_write_m[1]),
    .RegWrite_M(reg_write_m[1]), .Funct3_M(funct3_m[1]),
    .RegWrite_W(reg_write_w[1]), .ResultSrc_W(result_src_w[1])
  );

  // ---------------- scoreboard helpers ----------------
  function automatic string sig_name(input int s);
    case (s)
      SIG_IMM:    return "ImmSrc_D";
      SIG_ILL:    return "Illegal_D";
      SIG_SRCA:   return "AluSrcA_E";
      SIG_SRCB:   return "AluSrcB_E";
      SIG_ALU:    return "AluControl_E";
      SIG_LOADE:  return "LoadInE_E";
      SIG_PCSRC:  return "PCSrc_E";
      SIG_JALR:   return "PCJalr_E";
      SIG_MEMW_M: return "MemWrite_M";
      SIG_REGW_M: return "RegWrite_M";
      SIG_F3_M:   return "Funct3_M";
      SIG_REGW_W: return "RegWrite_W";
      default:    return "ResultSrc_W";
    endcase
  endfunction

  function automatic logic [7:0] actual(input int d, input int s);
    case (s)
      SIG_IMM:    return 8'(imm_src[d]);
      SIG_ILL:    return 8'(illegal[d]);
      SIG_SRCA:   return 8'(src_a[d]);
      SIG_SRCB:   return 8'(src_b[d]);
      SIG_ALU:    return 8'(alu_ctrl[d]);
      SIG_LOADE:  return 8'(load_e[d]);
      SIG_PCSRC:  return 8'(pc_src[d]);
      SIG_JALR:   return 8'(pc_jalr[d]);
      SIG_MEMW_M: return 8'(mem_write_m[d]);
      SIG_REGW_M: return 8'(reg_write_m[d]);
      SIG_F3_M:   return 8'(funct3_m[d]);
      SIG_REGW_W: return 8'(reg_write_w[d]);
      default:    return 8'(result_src_w[d]);
    endcase
  endfunction

  // Entry layout: [31:16] edge, [15:12] dut, [11:8] signal, [7:0] value.
  task automatic expect_at(input int e, input int d, input int s, input logic [7:0] v);
    exp_q.push_back({16'(e), 4'(d), 4'(s), v});
  endtask

  // Monitor: compare every expectation due at this edge, mid-cycle.
  always @(negedge Clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][31:16] == 16'(edges)) begin
        logic [7:0] act;
        int d, s;
        d = int'(exp_q[i][15:12]);
        s = int'(exp_q[i][11:8]);
        act = actual(d, s);
        n_compared++;
        if (act !== exp_q[i][7:0]) begin
          n_mismatched++;
          $display("FAIL %s dut%0d edge %0d: got %0d expected %0d",
                   sig_name(s), d, edges, act, exp_q[i][7:0]);
        end
        exp_q.delete(i);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic st, input logic fl,
                       input logic z, input logic lt, input logic ltu);
    Opcode_D = op; Funct3_D = f3; Funct7_5_D = f7;
    Stall_E = st; Flush_E = fl; Zero_E = z; Lt_E = lt; Ltu_E = ltu;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(OP_NOP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One decode vector: D outputs this cycle, EX outputs one edge later.
  task automatic do_dec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [3:0] alu, input logic sa, input logic [1:0] sb,
                        input logic [2:0] imm, input logic le);
    int n;
    n = edges;
    expect_at(n, 0, SIG_IMM, 8'(imm));
    expect_at(n, 0, SIG_ILL, 8'd0);
    expect_at(n + 1, 0, SIG_ALU, 8'(alu));
    expect_at(n + 1, 1, SIG_ALU, 8'(alu));
    expect_at(n + 1, 0, SIG_SRCA, 8'(sa));
    expect_at(n + 1, 0, SIG_SRCB, 8'(sb));
    expect_at(n + 1, 0, SIG_LOADE, 8'(le));
    drive(op, f3, f7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  logic [2:0] br_f3[$];
  logic [2:0] br_fl[$];   // {zero, lt, ltu}
  logic       br_exp[$];

  initial begin
    int n, n0;
    logic [2:0] fl;
    Reset = 1'b0;
    Opcode_D = OP_NOP; Funct3_D = 3'b000; Funct7_5_D = 1'b0;
    Stall_E = 1'b0; Flush_E = 1'b0; Zero_E = 1'b0; Lt_E = 1'b0; Ltu_E = 1'b0;

    // Reset state.
    for (int d = 0; d < 2; d++) begin
      expect_at(1, d, SIG_REGW_M, 8'd0);
      expect_at(1, d, SIG_MEMW_M, 8'd0);
      expect_at(1, d, SIG_REGW_W, 8'd0);
      expect_at(1, d, SIG_PCSRC, 8'd0);
      expect_at(1, d, SIG_JALR, 8'd0);
      expect_at(1, d, SIG_SRCB, 8'd0);
    end
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    idle(6);

    // R-type sub surrounded by NOPs: exact latency at EX, M and W.
    n = edges;
    expect_at(n, 0, SIG_IMM, 8'd0);
    expect_at(n, 0, SIG_ILL, 8'd0);
    expect_at(n + 1, 0, SIG_ALU, 8'd1);
    expect_at(n + 1, 0, SIG_SRCB, 8'd0);
    expect_at(n + 1, 0, SIG_PCSRC, 8'd0);
    expect_at(n + 2, 0, SIG_REGW_M, 8'd1);
    expect_at(n + 2, 1, SIG_REGW_M, 8'd1);
    expect_at(n + 2, 0, SIG_REGW_W, 8'd0);
    expect_at(n + 3, 0, SIG_REGW_W, 8'd1);
    expect_at(n + 3, 0, SIG_RES_W, 8'd0);
    expect_at(n + 4, 0, SIG_REGW_W, 8'd0);
    expect_at(n + 4, 1, SIG_REGW_W, 8'd0);
    expect_at(n + 5, 1, SIG_REGW_W, 8'd1);
    expect_at(n + 5, 1, SIG_RES_W, 8'd0);
    expect_at(n + 6, 1, SIG_REGW_W, 8'd0);
    drive(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Decode table: op, f3, f7_5, alu, srcA, srcB, imm, loadE.
    do_dec(OP_R,      3'b000, 1'b0, 4'b0000, 1'b0, 2'b00, 3'b000, 1'b0);
    do_dec(OP_R,      3'b101, 1'b1, 4'b1001, 1'b0, 2'b00, 3'b000, 1'b0);
    do_dec(OP_R,      3'b101, 1'b0, 4'b1000, 1'b0, 2'b00, 3'b000, 1'b0);
    do_dec(OP_R,      3'b011, 1'b0, 4'b0110, 1'b0, 2'b00, 3'b000, 1'b0);
    do_dec(OP_R,      3'b111, 1'b0, 4'b0010, 1'b0, 2'b00, 3'b000, 1'b0);
    do_dec(OP_R,      3'b110, 1'b0, 4'b0011, 1'b0, 2'b00, 3'b000, 1'b0);
    do_dec(OP_I,      3'b000, 1'b1, 4'b0000, 1'b0, 2'b01, 3'b000, 1'b0);
    do_dec(OP_I,      3'b101, 1'b1, 4'b1001, 1'b0, 2'b01, 3'b000, 1'b0);
    do_dec(OP_I,      3'b001, 1'b0, 4'b0111, 1'b0, 2'b01, 3'b000, 1'b0);
    do_dec(OP_I,      3'b100, 1'b0, 4'b0100, 1'b0, 2'b01, 3'b000, 1'b0);
    do_dec(OP_I,      3'b010, 1'b0, 4'b0101, 1'b0, 2'b01, 3'b000, 1'b0);
    do_dec(OP_LUI,    3'b000, 1'b0, 4'b1010, 1'b0, 2'b01, 3'b100, 1'b0);
    do_dec(OP_AUIPC,  3'b000, 1'b0, 4'b0000, 1'b1, 2'b01, 3'b100, 1'b0);
    do_dec(OP_LOAD,   3'b010, 1'b0, 4'b0000, 1'b0, 2'b01, 3'b000, 1'b1);
    do_dec(OP_STORE,  3'b010, 1'b0, 4'b0000, 1'b0, 2'b01, 3'b001, 1'b0);
    do_dec(OP_BRANCH, 3'b000, 1'b0, 4'b0001, 1'b0, 2'b00, 3'b010, 1'b0);
    idle(6);

    // Branch table, issued back to back; flags arrive while each is in EX.
    br_f3.push_back(3'b000); br_fl.push_back(3'b100); br_exp.push_back(1'b1);
    br_f3.push_back(3'b000); br_fl.push_back(3'b011); br_exp.push_back(1'b0);
    br_f3.push_back(3'b001); br_fl.push_back(3'b100); br_exp.push_back(1'b0);
    br_f3.push_back(3'b001); br_fl.push_back(3'b000); br_exp.push_back(1'b1);
    br_f3.push_back(3'b100); br_fl.push_back(3'b010); br_exp.push_back(1'b1);
    br_f3.push_back(3'b100); br_fl.push_back(3'b101); br_exp.push_back(1'b0);
    br_f3.push_back(3'b101); br_fl.push_back(3'b000); br_exp.push_back(1'b1);
    br_f3.push_back(3'b101); br_fl.push_back(3'b010); br_exp.push_back(1'b0);
    br_f3.push_back(3'b110); br_fl.push_back(3'b001); br_exp.push_back(1'b1);
    br_f3.push_back(3'b110); br_fl.push_back(3'b010); br_exp.push_back(1'b0);
    br_f3.push_back(3'b111); br_fl.push_back(3'b010); br_exp.push_back(1'b1);
    br_f3.push_back(3'b111); br_fl.push_back(3'b001); br_exp.push_back(1'b0);
    for (int c = 0; c < 8; c++) begin
      br_f3.push_back(3'b010); br_fl.push_back(3'(c)); br_exp.push_back(1'b0);
    end
    br_f3.push_back(3'b011); br_fl.push_back(3'b111); br_exp.push_back(1'b0);
    br_f3.push_back(3'b011); br_fl.push_back(3'b000); br_exp.push_back(1'b0);
    for (int i = 0; i <= br_f3.size(); i++) begin
      n = edges;
      if (i < br_f3.size()) begin
        expect_at(n + 1, 0, SIG_PCSRC, 8'(br_exp[i]));
        expect_at(n + 1, 1, SIG_PCSRC, 8'(br_exp[i]));
        expect_at(n + 1, 0, SIG_JALR, 8'd0);
        expect_at(n + 2, 0, SIG_REGW_M, 8'd0);
        expect_at(n + 2, 0, SIG_MEMW_M, 8'd0);
      end
      fl = (i > 0) ? br_fl[i-1] : 3'b000;
      if (i < br_f3.size())
        drive(OP_BRANCH, br_f3[i], 1'b0, 1'b0, 1'b0, fl[2], fl[1], fl[0]);
      else
        drive(OP_NOP, 3'b000, 1'b0, 1'b0, 1'b0, fl[2], fl[1], fl[0]);
    end
    idle(6);

    // JALR then JAL.
    n = edges;
    expect_at(n, 0, SIG_IMM, 8'd0);
    expect_at(n + 1, 0, SIG_JALR, 8'd1);
    expect_at(n + 1, 0, SIG_PCSRC, 8'd1);
    expect_at(n + 1, 0, SIG_SRCB, 8'd1);
    expect_at(n + 1, 0, SIG_ALU, 8'd0);
    expect_at(n + 2, 0, SIG_REGW_M, 8'd1);
    expect_at(n + 3, 0, SIG_REGW_W, 8'd1);
    expect_at(n + 3, 0, SIG_RES_W, 8'd2);
    expect_at(n + 5, 1, SIG_REGW_W, 8'd1);
    expect_at(n + 5, 1, SIG_RES_W, 8'd2);
    drive(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n = edges;
    expect_at(n, 0, SIG_IMM, 8'd3);
    expect_at(n + 1, 0, SIG_JALR, 8'd0);
    expect_at(n + 1, 0, SIG_PCSRC, 8'd1);
    expect_at(n + 3, 0, SIG_REGW_W, 8'd1);
    expect_at(n + 3, 0, SIG_RES_W, 8'd2);
    drive(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Sub-word load (lbu) and store (sh): funct3 reaches M.
    n = edges;
    expect_at(n + 1, 0, SIG_LOADE, 8'd1);
    expect_at(n + 2, 0, SIG_F3_M, 8'd4);
    expect_at(n + 2, 1, SIG_F3_M, 8'd4);
    expect_at(n + 2, 0, SIG_REGW_M, 8'd1);
    expect_at(n + 2, 0, SIG_MEMW_M, 8'd0);
    expect_at(n + 3, 0, SIG_RES_W, 8'd1);
    expect_at(n + 5, 1, SIG_RES_W, 8'd1);
    drive(OP_LOAD, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n = edges;
    expect_at(n + 1, 0, SIG_LOADE, 8'd0);
    expect_at(n + 2, 0, SIG_MEMW_M, 8'd1);
    expect_at(n + 2, 0, SIG_F3_M, 8'd1);
    expect_at(n + 2, 0, SIG_REGW_M, 8'd0);
    expect_at(n + 3, 0, SIG_REGW_W, 8'd0);
    drive(OP_STORE, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // sw held in EX for two stall cycles: bubbles into M, then the store.
    n = edges;
    expect_at(n + 1, 0, SIG_SRCB, 8'd1);
    expect_at(n + 2, 0, SIG_SRCB, 8'd1);
    expect_at(n + 3, 0, SIG_SRCB, 8'd1);
    expect_at(n + 4, 0, SIG_SRCB, 8'd0);
    expect_at(n + 2, 0, SIG_MEMW_M, 8'd0);
    expect_at(n + 3, 0, SIG_MEMW_M, 8'd0);
    expect_at(n + 3, 1, SIG_MEMW_M, 8'd0);
    expect_at(n + 4, 0, SIG_MEMW_M, 8'd1);
    expect_at(n + 4, 1, SIG_MEMW_M, 8'd1);
    expect_at(n + 4, 0, SIG_F3_M, 8'd2);
    expect_at(n + 5, 0, SIG_MEMW_M, 8'd0);
    drive(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(OP_NOP, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(OP_NOP, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Flush while a lw is being loaded into ID/EX: it never appears.
    n = edges;
    expect_at(n + 1, 0, SIG_LOADE, 8'd0);
    expect_at(n + 1, 0, SIG_SRCB, 8'd0);
    expect_at(n + 2, 0, SIG_REGW_M, 8'd0);
    expect_at(n + 3, 0, SIG_REGW_W, 8'd0);
    expect_at(n + 5, 1, SIG_REGW_W, 8'd0);
    drive(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Flush and stall together: EX cleared, addi in EX still reaches M/W.
    n = edges;
    expect_at(n + 1, 0, SIG_SRCB, 8'd1);
    expect_at(n + 2, 0, SIG_SRCB, 8'd0);
    expect_at(n + 2, 0, SIG_LOADE, 8'd0);
    expect_at(n + 2, 0, SIG_REGW_M, 8'd1);
    expect_at(n + 3, 0, SIG_REGW_M, 8'd0);
    expect_at(n + 3, 0, SIG_REGW_W, 8'd1);
    expect_at(n + 5, 1, SIG_REGW_W, 8'd1);
    drive(OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(OP_LOAD, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Illegal opcodes: flagged, no write enable downstream.
    n = edges;
    expect_at(n, 0, SIG_ILL, 8'd1);
    expect_at(n + 1, 0, SIG_ILL, 8'd1);
    expect_at(n + 2, 0, SIG_REGW_M, 8'd0);
    expect_at(n + 2, 0, SIG_MEMW_M, 8'd0);
    expect_at(n + 3, 0, SIG_REGW_M, 8'd0);
    expect_at(n + 3, 0, SIG_MEMW_M, 8'd0);
    expect_at(n + 3, 0, SIG_REGW_W, 8'd0);
    expect_at(n + 5, 1, SIG_REGW_W, 8'd0);
    expect_at(n + 6, 1, SIG_REGW_W, 8'd0);
    drive(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b1111011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Asynchronous reset with writes in flight, then NOPs after release.
    n0 = edges;
    expect_at(n0 + 5, 0, SIG_REGW_M, 8'd1);
    expect_at(n0 + 5, 0, SIG_REGW_W, 8'd1);
    expect_at(n0 + 5, 1, SIG_REGW_W, 8'd1);
    expect_at(n0 + 5, 0, SIG_SRCB, 8'd1);
    for (int k = 0; k < 6; k++) drive(OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    Opcode_D = OP_NOP;
    Reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      expect_at(n0 + 6, d, SIG_SRCB, 8'd0);
      expect_at(n0 + 6, d, SIG_PCSRC, 8'd0);
      for (int k = 6; k <= 11; k++) begin
        expect_at(n0 + k, d, SIG_REGW_M, 8'd0);
        expect_at(n0 + k, d, SIG_MEMW_M, 8'd0);
        expect_at(n0 + k, d, SIG_REGW_W, 8'd0);
      end
    end
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    idle(3);
    idle(4);

    // ---------------- final report ----------------
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL leftover_expectations: got %0d pending entries, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
